// File: rtl/control_seq_pkg.sv
// control_seq_pkg: shared types and default sizing for the control_seq_n sequencer.
//   state_e        - sequencer state encoding (IDLE=00, RUN=01, DONE=10)
//   N_LD_DEFAULT   - default number of load steps per pass
//   ITER_W_DEFAULT - default width of the pass-count input
package control_seq_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_e;

   localparam int unsigned N_LD_DEFAULT   = 4;
   localparam int unsigned ITER_W_DEFAULT = 4;

endpackage

// File: rtl/ctrl_step_decode.sv
// ctrl_step_decode: combinational step decoder for the control sequencer.
//   step  in  $clog2(N_LD)  current step index
//   run   in  1             sequencer is in RUN
//   hold  in  1             stall; masks the load strobes only
//   ld    out N_LD          one-hot load strobe for the current step
//   mux   out N_LD/2        mux[j] high on step 2j+1
module ctrl_step_decode #(
   parameter int unsigned N_LD = 4
) (
   input  logic [((N_LD > 1) ? $clog2(N_LD) : 1)-1:0] step,
   input  logic                                       run,
   input  logic                                       hold,
   output logic [N_LD-1:0]                            ld,
   output logic [N_LD/2-1:0]                          mux
);

   localparam int unsigned SW    = (N_LD > 1) ? $clog2(N_LD) : 1;
   localparam int unsigned N_MUX = N_LD / 2;

   always_comb begin
      ld  = '0;
      mux = '0;
      if (run) begin
         for (int i = 0; i < N_LD; i++) begin
            // The stall mask is applied here so the strobe drops in the same cycle.
            if (step == SW'(i)) ld[i] = ~hold;
         end
         for (int j = 0; j < N_MUX; j++) begin
            if (step == SW'(2 * j + 1)) mux[j] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/control_seq_n.sv
// control_seq_n: start/done sequencer for a register-load/mux datapath.
// On start it walks N_LD steps per pass (one load strobe per step, mux select
// on odd steps), repeats for iter passes (0 counts as 1), then pulses done.
//   clk        in  rising-edge clock
//   rst        in  synchronous active-high reset
//   start      in  begin a sequence (IDLE only)
//   iter       in  ITER_W  pass count, latched with start
//   hold       in  stall while RUN
//   abort      in  cancel; back to IDLE without done
//   ld         out N_LD    one-hot load strobes
//   mux        out N_LD/2  mux selects
//   busy       out high in RUN and DONE
//   first_pass out high on every step of pass 0
//   done       out one-cycle completion pulse
// N_LD must be even and at least 2.
module control_seq_n
   import control_seq_pkg::*;
#(
   parameter int unsigned N_LD   = N_LD_DEFAULT,
   parameter int unsigned ITER_W = ITER_W_DEFAULT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ITER_W-1:0] iter,
   input  logic              hold,
   input  logic              abort,
   output logic [N_LD-1:0]   ld,
   output logic [N_LD/2-1:0] mux,
   output logic              busy,
   output logic              first_pass,
   output logic              done
);

   localparam int unsigned N_MUX = N_LD / 2;
   localparam int unsigned SW    = (N_LD > 1) ? $clog2(N_LD) : 1;
   localparam logic [SW-1:0] LAST_STEP = SW'(N_LD - 1);

   state_e            state_q, state_d;
   logic [SW-1:0]     step_q, step_d;
   logic [ITER_W-1:0] pass_q, pass_d;
   logic [ITER_W-1:0] iter_q, iter_d;

   // One extra bit so an all-ones iter cannot wrap the pass comparison.
   logic [ITER_W:0]   pass_inc;
   logic              run;
   logic [N_MUX-1:0]  mux_dec;

   assign pass_inc = {1'b0, pass_q} + (ITER_W + 1)'(1);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         step_q  <= '0;
         pass_q  <= '0;
         iter_q  <= ITER_W'(1);
      end else begin
         state_q <= state_d;
         step_q  <= step_d;
         pass_q  <= pass_d;
         iter_q  <= iter_d;
      end
   end

   always_comb begin
      state_d = state_q;
      step_d  = step_q;
      pass_d  = pass_q;
      iter_d  = iter_q;
      unique case (state_q)
         IDLE: begin
            if (start && !abort) begin
               state_d = RUN;
               step_d  = '0;
               pass_d  = '0;
               iter_d  = (iter == '0) ? ITER_W'(1) : iter;
            end
         end
         RUN: begin
            if (abort) begin
               state_d = IDLE;
               step_d  = '0;
               pass_d  = '0;
            end else if (!hold) begin
               if (step_q != LAST_STEP) begin
                  step_d = step_q + SW'(1);
               end else if (pass_inc < {1'b0, iter_q}) begin
                  step_d = '0;
                  pass_d = pass_inc[ITER_W-1:0];
               end else begin
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
            step_d  = '0;
            pass_d  = '0;
         end
         default: begin
            state_d = IDLE;
            step_d  = '0;
            pass_d  = '0;
         end
      endcase
   end

   assign run = (state_q == RUN);

   ctrl_step_decode #(
      .N_LD (N_LD)
   ) u_decode (
      .step (step_q),
      .run  (run),
      .hold (hold),
      .ld   (ld),
      .mux  (mux_dec)
   );

   assign mux        = mux_dec;
   assign busy       = (state_q == RUN) || (state_q == DONE);
   assign first_pass = run && (pass_q == '0);
   assign done       = (state_q == DONE);

endmodule

// File: tb/tb_control_seq_n.sv
module tb_control_seq_n;
   import control_seq_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Default-parameter instance
   logic       rst, start, hold, abort;
   logic [3:0] iter;
   logic [3:0] ld;
   logic [1:0] mux;
   logic       busy, first_pass, done;

   // N_LD=8, ITER_W=2 instance
   logic       rst8, start8, hold8, abort8;
   logic [1:0] iter8;
   logic [7:0] ld8;
   logic [3:0] mux8;
   logic       busy8, fp8, done8;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   control_seq_n dut (
      .clk(clk), .rst(rst), .start(start), .iter(iter), .hold(hold), .abort(abort),
      .ld(ld), .mux(mux), .busy(busy), .first_pass(first_pass), .done(done)
   );

   control_seq_n #(.N_LD(8), .ITER_W(2)) dut8 (
      .clk(clk), .rst(rst8), .start(start8), .iter(iter8), .hold(hold8), .abort(abort8),
      .ld(ld8), .mux(mux8), .busy(busy8), .first_pass(fp8), .done(done8)
   );

   // Reference model: ph 0=idle 1=running 2=done; cnt = steps completed in this run.
   typedef struct {
      int ph;
      int cnt;
      int total;
   } m_t;

   m_t m4, m8;

   function automatic m_t m_next(m_t m, int n, logic r, logic s, logic a, logic h, int it);
      m_t x = m;
      if (r) begin
         x.ph  = 0;
         x.cnt = 0;
      end else begin
         case (m.ph)
            0: if (s && !a) begin
               x.ph    = 1;
               x.cnt   = 0;
               x.total = ((it == 0) ? 1 : it) * n;
            end
            1: if (a) x.ph = 0;
               else if (!h) begin
                  x.cnt = m.cnt + 1;
                  if (x.cnt == m.total) x.ph = 2;
               end
            default: x.ph = 0;
         endcase
      end
      return x;
   endfunction

   function automatic logic [31:0] e_ld(m_t m, int n, logic h);
      if (m.ph == 1 && !h) return 32'd1 << (m.cnt % n);
      return 32'd0;
   endfunction

   function automatic logic [31:0] e_mux(m_t m, int n);
      int s = m.cnt % n;
      if (m.ph == 1 && (s % 2) == 1) return 32'd1 << (s / 2);
      return 32'd0;
   endfunction

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("ld",    32'(ld),         e_ld(m4, 4, hold));
      chk("mux",   32'(mux),        e_mux(m4, 4));
      chk("busy",  32'(busy),       32'(m4.ph != 0));
      chk("fp",    32'(first_pass), 32'(m4.ph == 1 && m4.cnt < 4));
      chk("done",  32'(done),       32'(m4.ph == 2));
      chk("ld8",   32'(ld8),        e_ld(m8, 8, hold8));
      chk("mux8",  32'(mux8),       e_mux(m8, 8));
      chk("busy8", 32'(busy8),      32'(m8.ph != 0));
      chk("fp8",   32'(fp8),        32'(m8.ph == 1 && m8.cnt < 8));
      chk("done8", 32'(done8),      32'(m8.ph == 2));
   endtask

   // One rising edge: advance the model on the inputs seen at the edge, then compare.
   task automatic tick();
      m4 = m_next(m4, 4, rst, start, abort, hold, int'(iter));
      m8 = m_next(m8, 8, rst8, start8, abort8, hold8, int'(iter8));
      @(posedge clk);
      cyc++;
      #1;
      check_all();
   endtask

   // Ticks until done (bounded); checks edges elapsed since the start edge k.
   task automatic wait_done(string tag, int k, int exp_edges);
      int budget = 200;
      while (done !== 1'b1 && budget > 0) begin
         tick();
         budget--;
      end
      chk(tag, 32'(cyc - k), 32'(exp_edges));
   endtask

   initial begin
      int k, nfp, nld0;
      logic [3:0] ld_tab [4];
      logic [1:0] mux_tab [4];
      ld_tab  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
      mux_tab = '{2'b00, 2'b01, 2'b00, 2'b10};
      m4 = '{0, 0, 4};
      m8 = '{0, 0, 8};

      rst = 1; start = 0; hold = 0; abort = 0; iter = 4'd1;
      rst8 = 1; start8 = 0; hold8 = 0; abort8 = 0; iter8 = 2'd3;
      tick(); tick();
      rst = 0; rst8 = 0;
      tick();
      chk("reset_busy", 32'(busy), 32'd0);

      // iter=1: explicit strobe pattern and done latency
      start = 1; iter = 4'd1; tick(); k = cyc; start = 0;
      for (int i = 0; i < 4; i++) begin
         chk("seq_ld", 32'(ld), 32'(ld_tab[i]));
         chk("seq_mux", 32'(mux), 32'(mux_tab[i]));
         chk("seq_fp", 32'(first_pass), 32'd1);
         tick();
      end
      chk("seq_done", 32'(done), 32'd1);
      chk("seq_done_edge", 32'(cyc - k), 32'd4);
      tick();
      chk("seq_done_once", 32'(done), 32'd0);
      chk("seq_busy_off", 32'(busy), 32'd0);

      // iter=3: 12 load cycles, first_pass on first 4 only
      start = 1; iter = 4'd3; tick(); k = cyc; start = 0;
      nfp = 0; nld0 = 0;
      for (int i = 0; i < 12; i++) begin
         nfp  += int'(first_pass);
         nld0 += int'(ld[0]);
         if (i < 11) tick();
      end
      chk("it3_fp_cycles", 32'(nfp), 32'd4);
      chk("it3_ld0_cycles", 32'(nld0), 32'd3);
      wait_done("it3_done_edge", k, 12);
      tick();

      // iter=0 behaves as iter=1
      start = 1; iter = 4'd0; tick(); k = cyc; start = 0;
      wait_done("it0_done_edge", k, 4);
      tick();

      // hold two cycles at step 2
      start = 1; iter = 4'd1; tick(); k = cyc; start = 0;
      tick(); tick();
      hold = 1; #1;
      chk("hold_ld_mask", 32'(ld), 32'd0);
      tick(); tick();
      hold = 0; #1;
      chk("hold_resume_ld", 32'(ld), 32'b0100);
      wait_done("hold_done_edge", k, 6);
      tick();

      // abort at pass 1 step 3, then immediate restart
      start = 1; iter = 4'd2; tick(); start = 0;
      for (int i = 0; i < 7; i++) tick();
      chk("abort_at_step", 32'(ld), 32'b1000);
      abort = 1; tick(); abort = 0;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      start = 1; iter = 4'd1; tick(); start = 0;
      chk("abort_restart", 32'(ld), 32'b0001);
      tick();

      // reset mid-run with start/hold/abort all high
      rst = 1; start = 1; hold = 1; abort = 1; tick();
      rst = 0; hold = 0; abort = 0;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_ld", 32'(ld), 32'd0);
      // start held high: accepted again only from IDLE
      iter = 4'd1;
      for (int i = 0; i < 14; i++) tick();
      start = 0;
      for (int i = 0; i < 6; i++) tick();

      // start+abort in IDLE stays IDLE
      start = 1; abort = 1; tick(); start = 0; abort = 0;
      chk("start_abort_idle", 32'(busy), 32'd0);

      // all-ones iter: 15 passes, no wrap
      start = 1; iter = 4'hf; tick(); k = cyc; start = 0;
      wait_done("it15_done_edge", k, 60);
      tick();

      // N_LD=8, ITER_W=2, iter=3
      start8 = 1; iter8 = 2'd3; tick(); k = cyc; start8 = 0;
      for (int i = 0; i < 30 && done8 !== 1'b1; i++) tick();
      chk("n8_done_edge", 32'(cyc - k), 32'd24);
      tick();

      // randomized traffic on both instances
      for (int i = 0; i < 600; i++) begin
         start  = ($urandom_range(3) == 0);
         hold   = ($urandom_range(3) == 0);
         abort  = ($urandom_range(31) == 0);
         rst    = ($urandom_range(63) == 0);
         iter   = 4'($urandom_range(15));
         start8 = ($urandom_range(3) == 0);
         hold8  = ($urandom_range(3) == 0);
         abort8 = ($urandom_range(31) == 0);
         rst8   = ($urandom_range(63) == 0);
         iter8  = 2'($urandom_range(3));
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
